// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter sequencer around a handshaked instruction memory
//
// Fetches one instruction per REQ/EXEC pair. The datapath sees each fetched
// instruction for one committed execute cycle, and the next PC is chosen at
// commit time.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   imem_ack     in   instruction memory has data for imem_addr (only looked at in REQ)
//   SaltoCond    in   conditional branch decoded for the instruction in EXEC
//   oZero        in   ALU zero flag for the instruction in EXEC
//   extSigno     in   sign-extended branch offset, in words
//   stall        in   datapath hold; freezes EXEC
//   halt_req     in   go to HALT after the instruction in EXEC commits
//   resume       in   leave HALT
//   imem_req     out  fetch request, high for the whole REQ state
//   imem_addr    out  fetch address (always equal to pc)
//   instr_valid  out  the instruction in EXEC commits this cycle
//   pc           out  current program counter
//   halted       out  sequencer is in HALT
//   fetch_err    out  sticky fetch-timeout flag, cleared by resume
//   retired      out  committed instruction count, saturating
module pc_fetch_sequencer #(
  parameter int unsigned    AW        = 32,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [AW-1:0]  LAST_ADDR = AW'(255),
  parameter int unsigned    TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_ack,
  input  logic          SaltoCond,
  input  logic          oZero,
  input  logic [AW-1:0] extSigno,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          resume,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fetch_err,
  output logic [15:0]   retired
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc_n;
  logic [AW-1:0] next_pc;
  logic [3:0]    wait_cnt, wait_cnt_n;
  logic          err_n;
  logic [15:0]   retired_n;
  logic          commit;

  // Branch targets are taken as-is (modulo 2^AW); only the sequential step
  // from the last program address wraps back to the start.
  always_comb begin
    next_pc = pc + AW'(1);
    if (SaltoCond && oZero) begin
      next_pc = pc + AW'(1) + extSigno;
    end else if (pc == LAST_ADDR) begin
      next_pc = RESET_PC;
    end
  end

  assign commit = (state == S_EXEC) && !stall;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    wait_cnt_n = wait_cnt;
    err_n      = fetch_err;
    retired_n  = retired;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
      end
      S_REQ: begin
        // An ack on the final allowed wait cycle still wins over the timeout.
        if (imem_ack) begin
          state_n    = S_EXEC;
          wait_cnt_n = '0;
        end else if (wait_cnt + 4'd1 == TIMEOUT_CNT) begin
          state_n    = S_HALT;
          err_n      = 1'b1;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
      end
      S_EXEC: begin
        // stall takes priority over halt_req: nothing moves until released.
        if (commit) begin
          pc_n = next_pc;
          if (retired != 16'hFFFF) begin
            retired_n = retired + 16'd1;
          end
          state_n = halt_req ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_n = S_REQ;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      wait_cnt  <= wait_cnt_n;
      fetch_err <= err_n;
      retired   <= retired_n;
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = commit;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - scoreboard bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ack = 1'b0;
  logic        SaltoCond = 1'b0;
  logic        oZero = 1'b0;
  logic [31:0] extSigno = '0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        halted;
  logic        fetch_err;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int last_wait;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_commit[$];

  pc_fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_ack   (imem_ack),
    .SaltoCond  (SaltoCond),
    .oZero      (oZero),
    .extSigno   (extSigno),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expected value whenever the DUT shows a fetch handshake or a commit.
  always @(negedge clk) begin
    if (reset && imem_req && imem_ack) begin
      if (exp_fetch.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fetch_unexpected: got addr %0d expected no fetch", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
    end
    if (reset && instr_valid) begin
      if (exp_commit.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL commit_unexpected: got pc %0d expected no commit", pc);
      end else begin
        check("commit_pc", pc, exp_commit.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req;
    last_wait = 0;
    while (!imem_req && last_wait < 50) begin
      tick();
      last_wait++;
    end
    if (!imem_req) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req_timeout: got imem_req 0 expected 1");
    end
  endtask

  // One fetch + execute: ack immediately, then hold EXEC for nstall cycles before committing.
  task automatic do_instr(input logic [31:0] addr, input logic br, input logic z,
                          input logic [31:0] off, input int nstall, input logic hreq);
    wait_req();
    exp_fetch.push_back(addr);
    imem_ack = 1'b1;
    tick();
    imem_ack  = 1'b0;
    SaltoCond = br;
    oZero     = z;
    extSigno  = off;
    halt_req  = hreq;
    stall     = (nstall > 0);
    for (int i = 0; i < nstall; i++) begin
      #1;
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
      check("stall_pc", pc, addr);
      tick();
    end
    stall = 1'b0;
    exp_commit.push_back(addr);
    tick();
    SaltoCond = 1'b0;
    oZero     = 1'b0;
    extSigno  = '0;
    halt_req  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    reset = 1'b1;

    // Back-to-back sequential fetches: first REQ one cycle after release, then every 2nd cycle
    do_instr(32'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    check("first_req_latency", last_wait, 32'd1);
    for (int a = 1; a < 4; a++) begin
      do_instr(32'(a), 1'b0, 1'b0, 32'd0, 0, 1'b0);
      check("req_back_to_back", last_wait, 32'd0);
    end
    check("retired_after_4", {16'd0, retired}, 32'd4);

    // Branch taken backwards, then not taken
    do_instr(32'd4, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    do_instr(32'd5, 1'b1, 1'b1, -32'd3, 0, 1'b0);
    do_instr(32'd3, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    do_instr(32'd4, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    do_instr(32'd5, 1'b1, 1'b0, -32'd3, 0, 1'b0);
    do_instr(32'd6, 1'b0, 1'b0, 32'd0, 0, 1'b0);

    // Stall 3 cycles at pc=7
    do_instr(32'd7, 1'b0, 1'b0, 32'd0, 3, 1'b0);

    // Wrap at LAST_ADDR, and branch past it with no wrap
    do_instr(32'd8, 1'b1, 1'b1, 32'd246, 0, 1'b0);
    do_instr(32'd255, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    do_instr(32'd0, 1'b1, 1'b1, 32'd254, 0, 1'b0);
    do_instr(32'd255, 1'b1, 1'b1, 32'd4, 0, 1'b0);
    do_instr(32'd260, 1'b1, 1'b1, -32'd259, 0, 1'b0);

    // Halt after pc=2, inputs ignored while halted, then resume
    do_instr(32'd2, 1'b0, 1'b0, 32'd0, 0, 1'b1);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'd3);
    check("halt_imem_req", {31'd0, imem_req}, 32'd0);
    halt_req = 1'b1;
    stall    = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    halt_req = 1'b0;
    stall    = 1'b0;
    imem_ack = 1'b0;
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_hold_pc", pc, 32'd3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_halted", {31'd0, halted}, 32'd0);
    do_instr(32'd3, 1'b0, 1'b0, 32'd0, 0, 1'b0);

    // Timeout: 15 REQ cycles with no ack
    for (int i = 0; i < 14; i++) tick();
    check("to_cycle15_req", {31'd0, imem_req}, 32'd1);
    check("to_cycle15_err", {31'd0, fetch_err}, 32'd0);
    tick();
    check("to_halted", {31'd0, halted}, 32'd1);
    check("to_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("to_pc", pc, 32'd4);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("to_resume_err", {31'd0, fetch_err}, 32'd0);
    check("to_resume_req", {31'd0, imem_req}, 32'd1);
    check("to_resume_pc", pc, 32'd4);

    // Ack on the 15th REQ cycle is accepted
    for (int i = 0; i < 14; i++) tick();
    do_instr(32'd4, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    check("late_ack_err", {31'd0, fetch_err}, 32'd0);
    check("late_ack_halted", {31'd0, halted}, 32'd0);
    check("retired_total", {16'd0, retired}, 32'd19);

    // Asynchronous reset mid-REQ
    wait_req();
    check("pre_reset_pc", pc, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'd0);
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_retired", {16'd0, retired}, 32'd0);
    tick();
    reset = 1'b1;
    do_instr(32'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    check("restart_latency", last_wait, 32'd1);

    tick();
    check("fetch_queue_empty", exp_fetch.size(), 32'd0);
    check("commit_queue_empty", exp_commit.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
